spi_regfile: RTL and testbench

Parametrised SPI-slave configuration register file: a successor to the fixed five-register, write-only SPI peripheral. It synchronises an external mode-0 SPI bus into the system clock domain and decodes fixed-length frames into NUM_REGS registers of DATA_W bits. It adds register readback on sdo, a write strobe, and frame-error reporting. It sits between the chip pins and the PWM/control logic that consumes the register outputs.

---
 rtl/spi_regfile.sv | 162 ++++++++++++++++
 tb/tb_spi_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file: synchronised pins, R/W + address + data frames, readback on sdo.
// Pin edges act 3 clk later; no backpressure, the SPI master paces everything.
module spi_regfile #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       sdi,
    input  logic                       cs_n,
    output logic                       sdo,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, FLUSH} state_t;

    state_t              state, state_nxt;
    logic [2:0]          sclk_q, cs_q;
    logic [1:0]          sdi_q, fill_q;
    logic                armed;
    logic [FRAME_W-1:0]  shift;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   tx_shift, rd_data;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic                sdo_q;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, bit_take;
    logic hdr_rw, frm_rw, commit_go, do_write, do_err;
    logic [ADDR_W-1:0] hdr_addr, frm_addr;
    logic [DATA_W-1:0] frm_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            sdi_q  <= '0;
            cs_q   <= '1;
            fill_q <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            sdi_q  <= {sdi_q[0], sdi};
            cs_q   <= {cs_q[1:0], cs_n};
            fill_q <= {fill_q[0], 1'b1};
            // Only arm once cs_n has genuinely been seen high, so a chip select
            // held low across reset cannot open a frame.
            armed  <= armed | (fill_q[1] & cs_q[1]);
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2] & armed;
    assign bit_take  = sclk_rise & ~cs_rise & ~cs_q[1] & (state != IDLE);

    assign hdr_rw   = shift[ADDR_W];
    assign hdr_addr = shift[ADDR_W-1:0];
    assign frm_rw   = shift[FRAME_W-1];
    assign frm_addr = shift[FRAME_W-2 -: ADDR_W];
    assign frm_data = shift[DATA_W-1:0];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(NUM_REGS);
    endfunction

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_data = reg_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_nxt = ADDR;
                ADDR:  if (cnt == CNT_HDR) state_nxt = hdr_rw ? WDATA : RDATA;
                WDATA: if (cnt == CNT_MAX) state_nxt = FLUSH;
                RDATA: if (cnt == CNT_MAX) state_nxt = FLUSH;
                FLUSH: state_nxt = FLUSH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (state == IDLE && state_nxt == ADDR) begin
            shift <= '0;
            cnt   <= '0;
        end else if (bit_take) begin
            shift <= {shift[FRAME_W-2:0], sdi_q[1]};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            sdo_q    <= 1'b0;
        end else begin
            if (state == ADDR && state_nxt == RDATA) begin
                tx_shift <= rd_data;
            end else if (state == RDATA && sclk_fall && !cs_rise) begin
                tx_shift <= tx_shift << 1;
            end
            if (state_nxt != RDATA) begin
                sdo_q <= 1'b0;
            end else if (state == RDATA && sclk_fall && !cs_rise) begin
                sdo_q <= tx_shift[DATA_W-1];
            end
        end
    end

    assign sdo = sdo_q;

    assign commit_go = cs_rise && (state != IDLE) && (cnt != '0);
    assign do_write  = commit_go && (cnt == CNT_FULL) && frm_rw && in_range(frm_addr);
    assign do_err    = commit_go && !do_write && ((cnt != CNT_FULL) || frm_rw);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= do_write;
            frame_err <= do_err;
            if (do_write) begin
                wr_addr <= frm_addr;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frm_addr == ADDR_W'(i)) reg_q[i] <= frm_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = reg_q[g];
    end
endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: default instance (a) and 8x12-bit instance (b) share sclk/sdi.
// Frames are scored against an array model; pulses and readback are checked by a monitor.
module tb_spi_regfile;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        cs_n_a = 1'b1;
    logic        cs_n_b = 1'b1;
    logic        sdo_a, sdo_b;
    logic [39:0] regs_a;
    logic [95:0] regs_b;
    logic        wr_strobe_a, wr_strobe_b, frame_err_a, frame_err_b;
    logic [6:0]  wr_addr_a;
    logic [2:0]  wr_addr_b;

    spi_regfile dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs_n(cs_n_a), .sdo(sdo_a),
        .regs(regs_a), .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
    );

    spi_regfile #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(12)) dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs_n(cs_n_b), .sdo(sdo_b),
        .regs(regs_b), .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [6:0]  addr;
        logic [95:0] regs;
    } exp_t;

    exp_t        exp_q_a[$];
    exp_t        exp_q_b[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] act_rd_q[$];
    logic [11:0] mdl [2][8];
    int total = 0;
    int bad = 0;

    function automatic logic [95:0] flat(input int d);
        logic [95:0] v = '0;
        int dw = d ? 12 : 8;
        int nr = d ? 8 : 5;
        for (int i = 0; i < nr; i++)
            for (int b = 0; b < dw; b++) v[i*dw + b] = mdl[d][i][b];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_evt(input int d, input logic st, input logic er,
                             input logic [6:0] wa, input logic [95:0] rg);
        exp_t e;
        total++;
        if ((d == 0 && exp_q_a.size() == 0) || (d == 1 && exp_q_b.size() == 0)) begin
            bad++;
            $display("FAIL pulse_unexpected dut=%0d got strobe=%0b err=%0b required no pulse", d, st, er);
        end else begin
            e = (d == 1) ? exp_q_b.pop_front() : exp_q_a.pop_front();
            if (st !== ~e.is_err || er !== e.is_err || (!e.is_err && wa !== e.addr) || rg !== e.regs) begin
                bad++;
                $display("FAIL pulse dut=%0d got strobe=%0b err=%0b addr=%0d regs=%h required strobe=%0b err=%0b addr=%0d regs=%h",
                         d, st, er, wa, rg, ~e.is_err, e.is_err, e.addr, e.regs);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe_a || frame_err_a)
                check_evt(0, wr_strobe_a, frame_err_a, wr_addr_a, {56'b0, regs_a});
            if (wr_strobe_b || frame_err_b)
                check_evt(1, wr_strobe_b, frame_err_b, {4'b0, wr_addr_b}, regs_b);
            if (act_rd_q.size() > 0 && exp_rd_q.size() > 0)
                chk("readback_sdo", {64'b0, act_rd_q.pop_front()}, {64'b0, exp_rd_q.pop_front()});
        end
    end

    // Drives one frame MSB first; sdo is sampled just before each rising sclk.
    task automatic send(input int d, input logic [31:0] bits, input int n,
                        input int rst_after, output logic [31:0] smp);
        smp = '0;
        @(negedge clk);
        if (d == 1) cs_n_b = 1'b0; else cs_n_a = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = bits[i];
            repeat (H) @(negedge clk);
            smp = {smp[30:0], (d == 1) ? sdo_b : sdo_a};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            if (rst_after == n - i) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (H) @(negedge clk);
        cs_n_a = 1'b1;
        cs_n_b = 1'b1;
        sdi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input int d, input logic [31:0] bits, input int n, input int rst_after);
        int aw, dw, nr, fw;
        logic [31:0] addr, data, rdexp, smp;
        bit rw, is_rd;
        exp_t e;
        aw = d ? 3 : 7;
        dw = d ? 12 : 8;
        nr = d ? 8 : 5;
        fw = 1 + aw + dw;
        is_rd = 0;
        rdexp = '0;
        if (rst_after < 0 && n != 0) begin
            e.is_err = 1;
            e.addr = '0;
            if (n == fw) begin
                rw   = bits[fw-1];
                addr = (bits >> dw) & ((32'd1 << aw) - 1);
                data = bits & ((32'd1 << dw) - 1);
                if (rw && addr < nr) begin
                    mdl[d][addr] = data[11:0];
                    e.is_err = 0;
                    e.addr = addr[6:0];
                end else if (!rw) begin
                    is_rd = 1;
                    rdexp = (addr < nr) ? {20'b0, mdl[d][addr]} : 32'd0;
                end
            end
            e.regs = flat(d);
            if (!is_rd) begin
                if (d == 1) exp_q_b.push_back(e); else exp_q_a.push_back(e);
            end
        end
        send(d, bits, n, rst_after, smp);
        if (rst_after >= 0)
            for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) mdl[k][i] = '0;
        if (is_rd) begin
            exp_rd_q.push_back(rdexp);
            act_rd_q.push_back(smp & ((32'd1 << fw) - 1));
        end
        chk("regs_a_idle", {56'b0, regs_a}, flat(0));
        chk("regs_b_idle", regs_b, flat(1));
        chk("sdo_idle", {94'b0, sdo_a, sdo_b}, '0);
    endtask

    initial begin
        int d, kind, fw, dw, aw, n;
        logic [31:0] bits;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) mdl[k][i] = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_regs_a", {56'b0, regs_a}, '0);
        chk("reset_regs_b", regs_b, '0);
        chk("reset_outs_a", {88'b0, sdo_a, wr_strobe_a, frame_err_a, wr_addr_a}, '0);
        chk("reset_outs_b", {91'b0, sdo_b, wr_strobe_b, frame_err_b, wr_addr_b}, '0);
        repeat (5) @(negedge clk);

        do_frame(0, 32'h82A5, 16, -1);
        do_frame(0, 32'h0200, 16, -1);
        do_frame(0, 32'h8533, 16, -1);
        do_frame(0, 32'h082A, 12, -1);
        do_frame(0, 32'h10022, 17, -1);
        do_frame(0, 32'h8011, 16, -1);
        do_frame(0, 32'h0000, 0, -1);
        do_frame(0, 32'h0700, 16, -1);
        do_frame(0, 32'h0400, 14, -1);
        do_frame(1, 32'hFABC, 16, -1);
        do_frame(1, 32'h7000, 16, -1);
        do_frame(0, 32'h84FF, 16, 10);
        do_frame(0, 32'h84FF, 16, -1);
        do_frame(0, 32'h0400, 16, -1);
        do_frame(1, 32'h7000, 16, -1);

        for (int r = 0; r < 50; r++) begin
            d    = $urandom_range(0, 1);
            aw   = d ? 3 : 7;
            dw   = d ? 12 : 8;
            fw   = 1 + aw + dw;
            kind = $urandom_range(0, 9);
            bits = $urandom;
            if (kind == 0) n = 0;
            else if (kind == 1) n = fw - $urandom_range(1, 5);
            else if (kind == 2) n = fw + $urandom_range(1, 2);
            else begin
                n = fw;
                bits = (32'($urandom_range(0, 1)) << (fw - 1)) |
                       (32'($urandom_range(0, 7)) << dw) |
                       ($urandom & ((32'd1 << dw) - 1));
            end
            do_frame(d, bits, n, -1);
        end

        repeat (20) @(negedge clk);
        total++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0 || act_rd_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got a=%0d b=%0d rd=%0d required 0",
                     exp_q_a.size(), exp_q_b.size(), act_rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
